// File: rtl/pong_sound_arbiter.sv
// Speaker arbiter for the pong game.
// Three event sources (score, paddle hit, wall hit) share one speaker pin.
// The highest-priority request wins and plays a square-wave tone.
// The tone lasts a set number of frame ticks, taken from the falling edges of vsync.
// A strictly higher-priority request restarts the tone with its own pitch and length.
// Mute only masks the pin; timing keeps running underneath.
//
// state | meaning
// ------+---------------------------------------------
// IDLE  | no tone; waiting for any event
// PLAY  | tone active; counting half-periods and frames
module pong_sound_arbiter #(
  parameter logic [19:0] SCORE_HALF    = 20'd204082,
  parameter logic [19:0] PADDLE_HALF   = 20'd113636,
  parameter logic [19:0] WALL_HALF     = 20'd227273,
  parameter logic [5:0]  SCORE_FRAMES  = 6'd30,
  parameter logic [5:0]  PADDLE_FRAMES = 6'd3,
  parameter logic [5:0]  WALL_FRAMES   = 6'd2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       vsync_i,
  input  logic       score_evt_i,
  input  logic       paddle_hit_i,
  input  logic       wall_hit_i,
  input  logic       mute_i,
  output logic       speaker_o,
  output logic       busy_o,
  output logic [1:0] active_src_o
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } state_t;

  localparam logic [1:0] SRC_NONE   = 2'd0;
  localparam logic [1:0] SRC_WALL   = 2'd1;
  localparam logic [1:0] SRC_PADDLE = 2'd2;
  localparam logic [1:0] SRC_SCORE  = 2'd3;

  state_t      state_q;
  logic        vsync_q;
  logic        tick;
  logic        tone_q;
  logic        busy_q;
  logic [1:0]  src_q;
  logic [19:0] half_cnt_q;
  logic [19:0] half_per_q;
  logic [5:0]  frame_cnt_q;

  logic [1:0]  req_id_d;
  logic [19:0] req_half_d;
  logic [5:0]  req_frames_d;
  logic        grant_d;
  logic        half_wrap_d;

  // One-cycle frame tick on each falling edge of vsync.
  assign tick = vsync_q & ~vsync_i;

  // Fixed-priority encoder: the request id is also its priority.
  always_comb begin
    req_id_d     = SRC_NONE;
    req_half_d   = WALL_HALF;
    req_frames_d = WALL_FRAMES;
    if (score_evt_i) begin
      req_id_d     = SRC_SCORE;
      req_half_d   = SCORE_HALF;
      req_frames_d = SCORE_FRAMES;
    end else if (paddle_hit_i) begin
      req_id_d     = SRC_PADDLE;
      req_half_d   = PADDLE_HALF;
      req_frames_d = PADDLE_FRAMES;
    end else if (wall_hit_i) begin
      req_id_d     = SRC_WALL;
      req_half_d   = WALL_HALF;
      req_frames_d = WALL_FRAMES;
    end
  end

  // src_q is zero while idle, so one compare covers a fresh grant and a preemption.
  always_comb begin
    grant_d     = (req_id_d > src_q);
    half_wrap_d = (half_cnt_q == (half_per_q - 20'd1));
  end

  // Edge detector history; resets high so no tick fires right after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vsync_q <= 1'b1;
    end else begin
      vsync_q <= vsync_i;
    end
  end

  // Arbitration FSM with registered tone, busy and source outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      tone_q      <= 1'b0;
      busy_q      <= 1'b0;
      src_q       <= SRC_NONE;
      half_cnt_q  <= 20'd0;
      half_per_q  <= 20'd0;
      frame_cnt_q <= 6'd0;
    end else if (grant_d) begin
      // A grant or preemption reloads everything; a tick in this same cycle is ignored.
      state_q     <= ST_PLAY;
      tone_q      <= 1'b1;
      busy_q      <= 1'b1;
      src_q       <= req_id_d;
      half_cnt_q  <= 20'd0;
      half_per_q  <= req_half_d;
      frame_cnt_q <= req_frames_d;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q <= ST_IDLE;
        end
        ST_PLAY: begin
          if (half_wrap_d) begin
            half_cnt_q <= 20'd0;
            tone_q     <= ~tone_q;
          end else begin
            half_cnt_q <= half_cnt_q + 20'd1;
          end
          if (tick) begin
            if (frame_cnt_q == 6'd1) begin
              // Last frame: a lower or equal request in this cycle is simply dropped.
              state_q     <= ST_IDLE;
              tone_q      <= 1'b0;
              busy_q      <= 1'b0;
              src_q       <= SRC_NONE;
              half_cnt_q  <= 20'd0;
              frame_cnt_q <= 6'd0;
            end else begin
              frame_cnt_q <= frame_cnt_q - 6'd1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign speaker_o    = tone_q & ~mute_i;
  assign busy_o       = busy_q;
  assign active_src_o = src_q;

endmodule

// File: tb/tb_pong_sound_arbiter.sv
// Scoreboard bench for pong_sound_arbiter.
// A driver applies directed and random stimulus and updates a reference model of tones.
// The model tracks which tone is playing, when it started and how many frame ticks remain.
// At each clock edge it pushes the expected outputs into a queue.
// A monitor pops one entry every falling clock edge and compares it with the DUT.
module tb_pong_sound_arbiter;

  localparam int SH = 4, PH = 6, WH = 8;
  localparam int SF = 3, PF = 2, WF = 1;
  localparam int VPER = 100, VLOW = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vsync = 1'b1;
  logic       score_evt = 1'b0;
  logic       paddle_hit = 1'b0;
  logic       wall_hit = 1'b0;
  logic       mute = 1'b0;
  logic       speaker;
  logic       busy;
  logic [1:0] active_src;

  typedef struct {
    logic       tone;
    logic       busy;
    logic [1:0] src;
    int         edge_no;
  } exp_t;

  exp_t sb_q[$];

  int checks = 0;
  int failures = 0;
  int pushed = 0;
  int popped = 0;

  // reference model state
  int   n_edge = 0;
  int   m_src = 0;
  int   m_start = 0;
  int   m_left = 0;
  logic m_prev_vs = 1'b1;
  int   vcnt = 0;

  pong_sound_arbiter #(
    .SCORE_HALF   (20'd4),
    .PADDLE_HALF  (20'd6),
    .WALL_HALF    (20'd8),
    .SCORE_FRAMES (6'd3),
    .PADDLE_FRAMES(6'd2),
    .WALL_FRAMES  (6'd1)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .vsync_i     (vsync),
    .score_evt_i (score_evt),
    .paddle_hit_i(paddle_hit),
    .wall_hit_i  (wall_hit),
    .mute_i      (mute),
    .speaker_o   (speaker),
    .busy_o      (busy),
    .active_src_o(active_src)
  );

  always #5 clk = ~clk;

  function automatic int half_of(input int s);
    case (s)
      3: return SH;
      2: return PH;
      default: return WH;
    endcase
  endfunction

  function automatic int frames_of(input int s);
    case (s)
      3: return SF;
      2: return PF;
      default: return WF;
    endcase
  endfunction

  // Model update for the edge that samples the inputs currently driven.
  task automatic model_step();
    exp_t e;
    int   req;
    logic tk;
    n_edge++;
    if (rst) begin
      m_src = 0;
      m_left = 0;
      m_prev_vs = 1'b1;
    end else begin
      tk = m_prev_vs & ~vsync;
      m_prev_vs = vsync;
      req = score_evt ? 3 : paddle_hit ? 2 : wall_hit ? 1 : 0;
      if (req > m_src) begin
        m_src = req;
        m_start = n_edge;
        m_left = frames_of(req);
      end else if (m_src != 0 && tk) begin
        m_left--;
        if (m_left == 0) m_src = 0;
      end
    end
    e.busy = (m_src != 0);
    e.src = 2'(m_src);
    e.tone = (m_src != 0) && ((((n_edge - m_start) / half_of(m_src)) % 2) == 0);
    e.edge_no = n_edge;
    sb_q.push_back(e);
    pushed++;
  endtask

  task automatic clk_step();
    @(posedge clk);
    model_step();
    #1;
    rst = 1'b0;
    score_evt = 1'b0;
    paddle_hit = 1'b0;
    wall_hit = 1'b0;
    vcnt = (vcnt + 1) % VPER;
    vsync = (vcnt >= VPER - VLOW) ? 1'b0 : 1'b1;
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) clk_step();
  endtask

  // Monitor: compare one expected entry per cycle, away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        popped++;
        checks++;
        if (busy !== e.busy) begin
          failures++;
          $display("FAIL busy edge=%0d got=%0b exp=%0b", e.edge_no, busy, e.busy);
        end
        checks++;
        if (active_src !== e.src) begin
          failures++;
          $display("FAIL active_src edge=%0d got=%0d exp=%0d", e.edge_no, active_src, e.src);
        end
        checks++;
        if (speaker !== (e.tone & ~mute)) begin
          failures++;
          $display("FAIL speaker edge=%0d got=%0b exp=%0b mute=%0b", e.edge_no, speaker,
                   e.tone & ~mute, mute);
        end
      end
    end
  end

  // Driver: directed scenarios followed by random traffic.
  initial begin
    rst = 1'b1;
    run(1);
    rst = 1'b1;
    run(2);
    // idle after reset
    run(500);
    // paddle tone
    paddle_hit = 1'b1;
    run(1);
    run(300);
    // wall and score together: score wins
    wall_hit = 1'b1;
    score_evt = 1'b1;
    run(1);
    run(400);
    // wall tone preempted by paddle, then a wall hit is ignored
    run(VPER - vcnt + 2);
    wall_hit = 1'b1;
    run(1);
    run(10);
    paddle_hit = 1'b1;
    run(1);
    run(15);
    wall_hit = 1'b1;
    run(1);
    run(300);
    // muted score tone
    mute = 1'b1;
    score_evt = 1'b1;
    run(1);
    run(400);
    mute = 1'b0;
    run(5);
    // reset mid-tone, then a paddle hit two cycles later
    score_evt = 1'b1;
    run(1);
    run(20);
    rst = 1'b1;
    run(1);
    run(1);
    paddle_hit = 1'b1;
    run(1);
    run(300);
    // random traffic
    for (int i = 0; i < 4000; i++) begin
      score_evt  = ($urandom_range(0, 99) < 2);
      paddle_hit = ($urandom_range(0, 99) < 3);
      wall_hit   = ($urandom_range(0, 99) < 5);
      if ($urandom_range(0, 149) == 0) mute = ~mute;
      if ($urandom_range(0, 999) == 0) rst = 1'b1;
      clk_step();
    end
    mute = 1'b0;
    run(3);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (popped != pushed) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d exp=%0d", popped, pushed);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
